// File: rtl/display_scheduler_if.sv
// Bundle between the live/message sources and the display scheduler, plus the
// scheduler's outputs toward the seven-segment driver.
interface display_scheduler_if;
  localparam int unsigned DW = 16;
  localparam int unsigned PW = 2;

  logic          req0;
  logic [DW-1:0] dat0;
  logic [PW-1:0] ptr0;
  logic          req1;
  logic [DW-1:0] dat1;
  logic [PW-1:0] ptr1;
  logic          ack1;
  logic          busy;
  logic          ce;
  logic [DW-1:0] DAT;
  logic [PW-1:0] PTR;

  modport master (
    output req0, dat0, ptr0, req1, dat1, ptr1,
    input  ack1, busy, ce, DAT, PTR
  );

  modport slave (
    input  req0, dat0, ptr0, req1, dat1, ptr1,
    output ack1, busy, ce, DAT, PTR
  );
endinterface

// File: rtl/display_scheduler.sv
// Scan-enable generator and frame-aligned arbiter between a live source and a
// one-deep queued message source for a 4-digit multiplexed display driver.
module display_scheduler #(
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned HOLD_FRAMES = 250
) (
  input logic                clk,
  input logic                rst_n,
  display_scheduler_if.slave bus
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned HW = $clog2(HOLD_FRAMES) + 1;
  localparam int unsigned DW = 16;
  localparam int unsigned PW = 2;

  typedef enum logic {LIVE = 1'b0, MSG = 1'b1} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    fc;
  logic [HW-1:0] hold;
  logic          pend;
  logic [DW-1:0] qdat;
  logic [PW-1:0] qptr;

  logic tick;
  logic frame_end;
  logic hold_last;
  logic consume;
  logic accept;

  // Frame boundary is the prescaler wrap that also carries the digit index 3->0.
  always_comb begin
    tick      = (cnt == CW'(SCAN_DIV - 1));
    frame_end = tick && (fc == 2'd3);
    hold_last = (hold == HW'(HOLD_FRAMES - 1));
    consume   = frame_end && pend && ((state == LIVE) || hold_last);
    accept    = bus.req1 && (!pend || consume);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LIVE;
      cnt      <= '0;
      fc       <= '0;
      hold     <= '0;
      pend     <= 1'b0;
      qdat     <= '0;
      qptr     <= '0;
      bus.ce   <= 1'b0;
      bus.ack1 <= 1'b0;
      bus.busy <= 1'b0;
      bus.DAT  <= '0;
      bus.PTR  <= '0;
    end else begin
      bus.ce   <= tick;
      cnt      <= tick ? '0 : cnt + CW'(1);
      bus.ack1 <= accept;
      if (tick) fc <= fc + 2'd1;

      // A same-edge consume reads the old queue contents before the refill lands.
      if (accept) begin
        qdat <= bus.dat1;
        qptr <= bus.ptr1;
        pend <= 1'b1;
      end else if (consume) begin
        pend <= 1'b0;
      end

      if (frame_end) begin
        unique case (state)
          LIVE: begin
            if (pend) begin
              bus.DAT  <= qdat;
              bus.PTR  <= qptr;
              hold     <= '0;
              state    <= MSG;
              bus.busy <= 1'b1;
            end else if (bus.req0) begin
              bus.DAT <= bus.dat0;
              bus.PTR <= bus.ptr0;
            end
          end
          MSG: begin
            if (!hold_last) begin
              hold <= hold + HW'(1);
            end else if (pend) begin
              bus.DAT <= qdat;
              bus.PTR <= qptr;
              hold    <= '0;
            end else begin
              state    <= LIVE;
              bus.busy <= 1'b0;
              if (bus.req0) begin
                bus.DAT <= bus.dat0;
                bus.PTR <= bus.ptr0;
              end
            end
          end
          default: state <= LIVE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with SCAN_DIV=4, HOLD_FRAMES=3 (frame every 16 edges).
module tb_display_scheduler;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   edge_n;

  display_scheduler_if bus ();

  display_scheduler #(
    .SCAN_DIV   (4),
    .HOLD_FRAMES(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to just after rising edge n (counted from reset release).
  task automatic step_to(input int n);
    while (edge_n < n) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    bus.req0 = 1'b0;
    bus.dat0 = 16'h0000;
    bus.ptr0 = 2'd0;
    bus.req1 = 1'b0;
    bus.dat1 = 16'h0000;
    bus.ptr1 = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    edge_n = 0;
  endtask

  task automatic test_reset();
    logic exp_ce;
    rst_n    = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.dat0 = 16'h0000;
    bus.ptr0 = 2'd0;
    bus.dat1 = 16'h0000;
    bus.ptr1 = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.ce !== 1'b0 || bus.DAT !== 16'h0000 || bus.PTR !== 2'd0 ||
        bus.busy !== 1'b0 || bus.ack1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: ce=%b DAT=%h PTR=%0d busy=%b ack1=%b want all zero",
               bus.ce, bus.DAT, bus.PTR, bus.busy, bus.ack1);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    edge_n = 0;
    for (int k = 1; k <= 16; k++) begin
      step_to(k);
      exp_ce = ((k % 4) == 0);
      n_checks++;
      if (bus.ce !== exp_ce) begin
        n_fail++;
        $display("FAIL scan_ce_edge%0d: got %b want %b", k, bus.ce, exp_ce);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.ce !== 1'b0 || bus.DAT !== 16'h0000 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_ce: ce=%b DAT=%h busy=%b want 0/0000/0", bus.ce, bus.DAT, bus.busy);
    end
  endtask

  task automatic test_live();
    do_reset();
    step_to(5);
    bus.req0 = 1'b1;
    bus.dat0 = 16'h1234;
    bus.ptr0 = 2'd2;
    step_to(15);
    n_checks++;
    if (bus.DAT !== 16'h0000 || bus.PTR !== 2'd0) begin
      n_fail++;
      $display("FAIL live_before_frame: DAT=%h PTR=%0d want 0000/0", bus.DAT, bus.PTR);
    end
    step_to(16);
    n_checks++;
    if (bus.DAT !== 16'h1234 || bus.PTR !== 2'd2) begin
      n_fail++;
      $display("FAIL live_frame16: DAT=%h PTR=%0d want 1234/2", bus.DAT, bus.PTR);
    end
    step_to(20);
    bus.dat0 = 16'h5678;
    step_to(31);
    n_checks++;
    if (bus.DAT !== 16'h1234) begin
      n_fail++;
      $display("FAIL live_midframe_hold: DAT=%h want 1234", bus.DAT);
    end
    step_to(32);
    n_checks++;
    if (bus.DAT !== 16'h5678 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL live_frame32: DAT=%h busy=%b want 5678/0", bus.DAT, bus.busy);
    end
  endtask

  task automatic test_preempt();
    do_reset();
    bus.req0 = 1'b1;
    bus.dat0 = 16'h1234;
    bus.ptr0 = 2'd2;
    step_to(20);
    bus.req1 = 1'b1;
    bus.dat1 = 16'hABCD;
    bus.ptr1 = 2'd1;
    step_to(21);
    bus.req1 = 1'b0;
    n_checks++;
    if (bus.ack1 !== 1'b1) begin
      n_fail++;
      $display("FAIL preempt_ack: ack1=%b want 1", bus.ack1);
    end
    step_to(22);
    n_checks++;
    if (bus.ack1 !== 1'b0) begin
      n_fail++;
      $display("FAIL preempt_ack_pulse: ack1=%b want 0", bus.ack1);
    end
    step_to(31);
    n_checks++;
    if (bus.DAT !== 16'h1234 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL preempt_before: DAT=%h busy=%b want 1234/0", bus.DAT, bus.busy);
    end
    step_to(32);
    n_checks++;
    if (bus.DAT !== 16'hABCD || bus.PTR !== 2'd1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL preempt_show: DAT=%h PTR=%0d busy=%b want ABCD/1/1", bus.DAT, bus.PTR, bus.busy);
    end
    step_to(40);
    bus.dat0 = 16'h9999;
    bus.ptr0 = 2'd3;
    step_to(64);
    n_checks++;
    if (bus.DAT !== 16'hABCD || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL preempt_hold64: DAT=%h busy=%b want ABCD/1", bus.DAT, bus.busy);
    end
    step_to(79);
    n_checks++;
    if (bus.DAT !== 16'hABCD || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL preempt_hold79: DAT=%h busy=%b want ABCD/1", bus.DAT, bus.busy);
    end
    step_to(80);
    n_checks++;
    if (bus.DAT !== 16'h9999 || bus.PTR !== 2'd3 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL preempt_release: DAT=%h PTR=%0d busy=%b want 9999/3/0", bus.DAT, bus.PTR, bus.busy);
    end
  endtask

  task automatic test_queue_full();
    do_reset();
    step_to(2);
    bus.req1 = 1'b1;
    bus.dat1 = 16'hABCD;
    bus.ptr1 = 2'd1;
    step_to(3);
    bus.req1 = 1'b0;
    step_to(20);
    bus.req1 = 1'b1;
    bus.dat1 = 16'hEEEE;
    bus.ptr1 = 2'd3;
    step_to(21);
    bus.req1 = 1'b0;
    n_checks++;
    if (bus.ack1 !== 1'b1) begin
      n_fail++;
      $display("FAIL qfull_ack_eeee: ack1=%b want 1", bus.ack1);
    end
    step_to(24);
    bus.req1 = 1'b1;
    bus.dat1 = 16'hFFFF;
    bus.ptr1 = 2'd0;
    step_to(25);
    bus.req1 = 1'b0;
    n_checks++;
    if (bus.ack1 !== 1'b0) begin
      n_fail++;
      $display("FAIL qfull_drop_ffff: ack1=%b want 0", bus.ack1);
    end
    step_to(48);
    n_checks++;
    if (bus.DAT !== 16'hABCD || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL qfull_abcd48: DAT=%h busy=%b want ABCD/1", bus.DAT, bus.busy);
    end
    step_to(64);
    n_checks++;
    if (bus.DAT !== 16'hEEEE || bus.PTR !== 2'd3 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL qfull_chain64: DAT=%h PTR=%0d busy=%b want EEEE/3/1", bus.DAT, bus.PTR, bus.busy);
    end
    step_to(96);
    n_checks++;
    if (bus.DAT !== 16'hEEEE || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL qfull_hold96: DAT=%h busy=%b want EEEE/1", bus.DAT, bus.busy);
    end
    step_to(112);
    n_checks++;
    if (bus.DAT !== 16'hEEEE || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL qfull_end112: DAT=%h busy=%b want EEEE/0", bus.DAT, bus.busy);
    end
    step_to(128);
    n_checks++;
    if (bus.DAT !== 16'hEEEE || bus.PTR !== 2'd3) begin
      n_fail++;
      $display("FAIL qfull_no_ffff: DAT=%h PTR=%0d want EEEE/3", bus.DAT, bus.PTR);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step_to(2);
    bus.req1 = 1'b1;
    bus.dat1 = 16'hCCCC;
    bus.ptr1 = 2'd2;
    step_to(3);
    bus.req1 = 1'b0;
    step_to(15);
    bus.req1 = 1'b1;
    bus.dat1 = 16'hDDDD;
    bus.ptr1 = 2'd1;
    step_to(16);
    bus.req1 = 1'b0;
    n_checks++;
    if (bus.DAT !== 16'hCCCC || bus.PTR !== 2'd2 || bus.ack1 !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_consume16: DAT=%h PTR=%0d ack1=%b busy=%b want CCCC/2/1/1",
               bus.DAT, bus.PTR, bus.ack1, bus.busy);
    end
    step_to(63);
    n_checks++;
    if (bus.DAT !== 16'hCCCC) begin
      n_fail++;
      $display("FAIL b2b_hold63: DAT=%h want CCCC", bus.DAT);
    end
    step_to(64);
    n_checks++;
    if (bus.DAT !== 16'hDDDD || bus.PTR !== 2'd1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_next64: DAT=%h PTR=%0d busy=%b want DDDD/1/1", bus.DAT, bus.PTR, bus.busy);
    end
    step_to(112);
    n_checks++;
    if (bus.DAT !== 16'hDDDD || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end112: DAT=%h busy=%b want DDDD/0", bus.DAT, bus.busy);
    end
  endtask

  task automatic test_reset_mid_message();
    do_reset();
    step_to(2);
    bus.req1 = 1'b1;
    bus.dat1 = 16'hABCD;
    bus.ptr1 = 2'd1;
    step_to(3);
    bus.req1 = 1'b0;
    step_to(20);
    bus.req1 = 1'b1;
    bus.dat1 = 16'hEEEE;
    bus.ptr1 = 2'd3;
    step_to(21);
    bus.req1 = 1'b0;
    step_to(30);
    n_checks++;
    if (bus.DAT !== 16'hABCD || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_pre: DAT=%h busy=%b want ABCD/1", bus.DAT, bus.busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.DAT !== 16'h0000 || bus.PTR !== 2'd0 || bus.busy !== 1'b0 || bus.ack1 !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_async: DAT=%h PTR=%0d busy=%b ack1=%b want 0000/0/0/0",
               bus.DAT, bus.PTR, bus.busy, bus.ack1);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    edge_n = 0;
    for (int f = 1; f <= 7; f++) begin
      step_to(f * 16);
      n_checks++;
      if (bus.DAT !== 16'h0000 || bus.busy !== 1'b0 || bus.ack1 !== 1'b0) begin
        n_fail++;
        $display("FAIL rmid_lost_frame%0d: DAT=%h busy=%b ack1=%b want 0000/0/0",
                 f, bus.DAT, bus.busy, bus.ack1);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    edge_n   = 0;
    test_reset();
    test_live();
    test_preempt();
    test_queue_full();
    test_back_to_back();
    test_reset_mid_message();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
